// File: rtl/comp_nbit_seq_if.sv
// Operand/control bus for the sequential N-bit comparator.
// The master streams W-bit chunks; the slave returns busy/result.
interface comp_nbit_seq_if #(
  parameter int W = 4
);
  logic         start;
  logic [1:0]   op;
  logic         is_signed;
  logic         in_valid;
  logic [W-1:0] g_input;
  logic [W-1:0] e_input;
  logic         busy;
  logic         o;
  logic         o_valid;

  modport master (
    output start, op, is_signed, in_valid, g_input, e_input,
    input  busy, o, o_valid
  );

  modport slave (
    input  start, op, is_signed, in_valid, g_input, e_input,
    output busy, o, o_valid
  );
endinterface

// File: rtl/comp_nbit_seq.sv
// Sequential comparator: consumes N-bit operands as N/W chunks, LSB chunk first,
// and reports g op e (GE/GT/EQ/NE), signed or unsigned, one cycle after the last chunk.
module comp_nbit_seq #(
  parameter int N = 8,
  parameter int W = 4
) (
  input logic            clk,
  input logic            rst_n,
  comp_nbit_seq_if.slave bus
);
  localparam int            K    = N / W;
  localparam int            CW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_gt;
  logic          r_eq;
  logic          r_o;
  logic [1:0]    r_op;
  logic          r_signed;

  logic w_start_ok;
  logic w_accept;
  logic w_last;
  logic w_chunk_gt;
  logic w_chunk_lt;
  logic w_gt_nxt;
  logic w_eq_nxt;

  function automatic logic f_result(input logic [1:0] op, input logic gt, input logic eq);
    case (op)
      2'b00:   f_result = gt | eq;
      2'b01:   f_result = gt;
      2'b10:   f_result = eq;
      default: f_result = ~eq;
    endcase
  endfunction

  // A higher chunk overrides whatever lower chunks decided; equal chunks keep it.
  always_comb begin
    w_start_ok = bus.start && (r_state != RUN);
    w_accept   = (r_state == RUN) && bus.in_valid;
    w_last     = (r_cnt == LAST);
    if (w_last && r_signed) begin
      w_chunk_gt = $signed(bus.g_input) > $signed(bus.e_input);
      w_chunk_lt = $signed(bus.g_input) < $signed(bus.e_input);
    end else begin
      w_chunk_gt = bus.g_input > bus.e_input;
      w_chunk_lt = bus.g_input < bus.e_input;
    end
    w_gt_nxt = r_gt;
    w_eq_nxt = r_eq;
    if (w_chunk_gt) begin
      w_gt_nxt = 1'b1;
      w_eq_nxt = 1'b0;
    end else if (w_chunk_lt) begin
      w_gt_nxt = 1'b0;
      w_eq_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_start_ok ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b1;
      r_o      <= 1'b0;
      r_op     <= 2'b00;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_op     <= bus.op;
        r_signed <= bus.is_signed;
        r_gt     <= 1'b0;
        r_eq     <= 1'b1;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_gt <= w_gt_nxt;
        r_eq <= w_eq_nxt;
        if (w_last) begin
          r_o <= f_result(r_op, w_gt_nxt, w_eq_nxt);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.busy    = (r_state == RUN);
  assign bus.o_valid = (r_state == DONE);
  assign bus.o       = r_o;
endmodule

// File: doc/comp_nbit_seq.md
Name: comp_nbit_seq

Overview:
Sequential, parametrised successor to the single-cycle N-bit comparator for garbled-circuit synthesis. The block takes two N-bit operands, g_input (garbler) and e_input (evaluator), as a stream of W-bit chunks, least-significant chunk first, over N/W accepted cycles. It supports signed and unsigned operands and four compare operations. Gate count is fixed by W, not N, so the block serves wide operands in multi-cycle garbled netlists.

Parameters:
N, 8, total operand width in bits; must satisfy N % W == 0.
W, 4, chunk width consumed per accepted cycle; 1 <= W <= N.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  begin a new comparison; latches op and is_signed.
op  input  2  compare operation: 00 GE, 01 GT, 10 EQ, 11 NE.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
in_valid  input  1  current g_input/e_input chunk is valid.
g_input  input  W  garbler operand chunk.
e_input  input  W  evaluator operand chunk.
busy  output  1  comparison in progress; start is ignored while high.
o  output  1  comparison result (g op e).
o_valid  output  1  one-cycle pulse; o is valid.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: busy=0, o=0, o_valid=0, state=IDLE, chunk counter=0, internal gt=0 and eq=1.
- Chunk count: K = N/W. Counter width is max(1, clog2(K)).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op and is_signed, clears gt=0 and eq=1 and counter=0, then moves to RUN.
  - in_valid is ignored in IDLE, including in the start cycle.
- RUN:
  - busy=1. Each cycle with in_valid=1 consumes one chunk. Cycles with in_valid=0 are bubbles with no state change.
  - Non-final chunk, compared unsigned:
    - g > e: gt=1, eq=0.
    - g < e: gt=0, eq=0.
    - g == e: gt and eq unchanged.
  - Final chunk (counter == K-1) is the MSB chunk. It is compared signed W-bit if is_signed=1, otherwise unsigned, using the same update rule. The state then moves to DONE.
  - When K=1 the single chunk is the MSB chunk.
- DONE, exactly one cycle:
  - o_valid=1, busy=0.
  - o is computed from the final gt/eq: GE = gt|eq, GT = gt, EQ = eq, NE = ~eq.
  - The next state is IDLE. start in DONE is accepted exactly as in IDLE, giving back-to-back operations.
- Latency: o_valid asserts in the cycle after the clock edge that accepts the final chunk.
- Output hold: o holds its value until the next DONE or reset. o_valid is high only in DONE.
- start while busy=1 is ignored, and op/is_signed changes are ignored. The latched values apply for the whole operation.
- Reset mid-operation returns to IDLE with all outputs at their reset values. No partial o_valid is produced.
- is_signed affects only the MSB chunk. EQ/NE results are identical for signed and unsigned operands.

Test Plan:
1. N=8, W=4, unsigned GE. Operands g=A9, e=7B, streamed as chunks (9,B) then (A,7) on consecutive cycles. Required: o=1 and o_valid for exactly one cycle, in the cycle after the second chunk is accepted; busy=0 in that cycle.
2. Operands g=74, e=FD, run once unsigned and once signed. Unsigned GE -> o=0. Signed GE -> o=1 (116 >= -3). Signed GT -> o=1.
3. Operands g=AA, e=AA, run as four separate operations. Required: GE -> 1, GT -> 0, EQ -> 1, NE -> 0.
4. g=A9, e=7B, unsigned GE, with in_valid=0 for 3 cycles between the two chunks. Required: o=1, and o_valid one cycle after the second accepted chunk. Also, in_valid=1 in IDLE with no start produces no o_valid.
5. Start g=74/e=FD unsigned GE and assert rst_n=0 after the first chunk. Required: busy=0, o=0, o_valid=0 immediately. A following g=A9/e=7B GE operation then gives o=1.
6. Pulse start with op=EQ while busy during a GE op on g=A9/e=7B. Required: the pulse is ignored and the result is o=1 (GE). Then assert start in the DONE cycle for a second op (g=74, e=FD, unsigned GT). Required: it is accepted back-to-back and gives o=0.
